pulse_spacer: RTL and testbench

- Sits directly upstream of pulse_cdc in the source (aclk) domain.
- Accepts bursty single-cycle event requests and queues them in a saturating pending counter.
- Re-emits them as single-cycle pulses spaced at least MIN_GAP aclk cycles apart, so the toggle-based pulse_cdc never receives pulses closer than it can carry to bclk.
- Drops events only on counter saturation, and flags each drop with a sticky overflow bit.

---
 rtl/pulse_spacer.sv | 52 +++++
 tb/tb_pulse_spacer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/pulse_spacer.sv
// pulse_spacer: queues bursty events and re-emits them as pulses spaced MIN_GAP aclk cycles apart
module pulse_spacer #(
    parameter int MIN_GAP = 6,
    parameter int CNT_W   = 8
) (
    input  logic             i_aclk,
    input  logic             i_aclk_rst_n,
    input  logic             i_event,
    input  logic             i_clr_overflow,
    output logic             o_pulse_aclk,
    output logic [CNT_W-1:0] o_pending,
    output logic             o_overflow,
    output logic             o_busy
);
    typedef enum logic {READY, GAP} state_t;
    localparam logic [CNT_W-1:0] PEND_MAX = '1;
    localparam logic [7:0]       GAP_LOAD = 8'(MIN_GAP - 1);
    state_t           state, state_next;
    logic [7:0]       gap_cnt, gap_next;
    logic [CNT_W-1:0] pending_next;
    logic             fire, drop, overflow_next, busy_next;
    // state, gap counter, queue depth and all outputs are registered here
    always_ff @(posedge i_aclk or negedge i_aclk_rst_n) begin
        if (!i_aclk_rst_n) begin
            state        <= READY;
            gap_cnt      <= '0;
            o_pending    <= '0;
            o_pulse_aclk <= 1'b0;
            o_overflow   <= 1'b0;
            o_busy       <= 1'b0;
        end else begin
            state        <= state_next;
            gap_cnt      <= gap_next;
            o_pending    <= pending_next;
            o_pulse_aclk <= fire;
            o_overflow   <= overflow_next;
            o_busy       <= busy_next;
        end
    end
    // fire decision, gap countdown, saturating queue update and sticky overflow
    always_comb begin
        fire          = (state == READY) && (o_pending != '0 || i_event);
        drop          = i_event && !fire && (o_pending == PEND_MAX);
        pending_next  = (i_event && !fire && !drop) ? o_pending + 1'b1 :
                        (fire && !i_event)          ? o_pending - 1'b1 : o_pending;
        gap_next      = fire ? GAP_LOAD : (state == GAP) ? gap_cnt - 8'd1 : gap_cnt;
        state_next    = fire ? ((MIN_GAP > 1) ? GAP : READY) :
                        (state == GAP && gap_cnt == 8'd1) ? READY : state;
        overflow_next = drop || (o_overflow && !i_clr_overflow);
        busy_next     = (pending_next != '0) || (gap_next != 8'd0);
    end
endmodule

// File: tb/tb_pulse_spacer.sv
// tb_pulse_spacer: directed and randomized checks of pulse_spacer against an edge-count model
module tb_pulse_spacer;
    localparam int MIN_GAP = 6;
    localparam int CNT_W   = 3;
    localparam int MAXP    = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n, ev, clr;
    logic             pulse, overflow, busy;
    logic [CNT_W-1:0] pending;
    int               checks = 0;
    int               errors = 0;

    int m_edge, m_last, m_pending;
    bit m_pulse, m_ovf, m_busy;

    pulse_spacer #(.MIN_GAP(MIN_GAP), .CNT_W(CNT_W)) dut (
        .i_aclk(clk),
        .i_aclk_rst_n(rst_n),
        .i_event(ev),
        .i_clr_overflow(clr),
        .o_pulse_aclk(pulse),
        .o_pending(pending),
        .o_overflow(overflow),
        .o_busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // model: a fire may happen once MIN_GAP edges have elapsed since the last fire
    always @(posedge clk or negedge rst_n) begin
        int e, lf, np;
        bit rdy, f, d;
        if (!rst_n) begin
            m_edge    <= 0;
            m_last    <= -1000;
            m_pending <= 0;
            m_pulse   <= 1'b0;
            m_ovf     <= 1'b0;
            m_busy    <= 1'b0;
        end else begin
            e   = m_edge + 1;
            rdy = (e - m_last) >= MIN_GAP;
            f   = rdy && (m_pending > 0 || ev);
            lf  = f ? e : m_last;
            d   = ev && !f && (m_pending == MAXP);
            np  = d ? MAXP : m_pending + int'(ev) - int'(f);
            m_edge    <= e;
            m_last    <= lf;
            m_pending <= np;
            m_pulse   <= f;
            m_ovf     <= d ? 1'b1 : (clr ? 1'b0 : m_ovf);
            m_busy    <= (np != 0) || ((e - lf) < MIN_GAP - 1);
        end
    end

    // compare against model every cycle out of reset, and check pulse spacing directly
    int cyc = 0;
    int last_p = -1000;
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) last_p = -1000;
        else if (!clk) begin
            cyc++;
            chk("pulse", int'(pulse), int'(m_pulse));
            chk("pending", int'(pending), m_pending);
            chk("overflow", int'(overflow), int'(m_ovf));
            chk("busy", int'(busy), int'(m_busy));
            if (pulse) begin
                chk("spacing_ok", int'(cyc - last_p >= MIN_GAP), 1);
                last_p = cyc;
            end
        end
    end

    initial begin
        int n, peak, dens;
        bit seen;
        ev = 0; clr = 0; rst_n = 0;
        repeat (3) @(negedge clk);
        chk("rst_pulse", int'(pulse), 0);
        chk("rst_pending", int'(pending), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_busy", int'(busy), 0);
        rst_n = 1;
        repeat (4) @(negedge clk);
        ev = 1;
        @(negedge clk);
        ev = 0;
        chk("single_pulse", int'(pulse), 1);
        chk("single_pending", int'(pending), 0);
        n = 0; peak = 0;
        for (int i = 0; i < 12; i++) begin
            n += int'(busy);
            peak += int'(pulse);
            @(negedge clk);
        end
        chk("single_busy_cycles", n, MIN_GAP - 1);
        chk("single_pulse_count", peak, 1);
        n = 0; peak = 0;
        for (int i = 0; i < 30; i++) begin
            ev = (i < 4);
            @(negedge clk);
            n += int'(pulse);
            if (int'(pending) > peak) peak = int'(pending);
        end
        chk("burst_pulses", n, 4);
        chk("burst_peak", peak, 3);
        chk("burst_end_pending", int'(pending), 0);
        chk("burst_overflow", int'(overflow), 0);
        ev = 1;
        repeat (20) @(negedge clk);
        chk("sat_pending", int'(pending), MAXP);
        chk("sat_overflow", int'(overflow), 1);
        seen = 0;
        for (int i = 0; i < 3 * MIN_GAP && !seen; i++) begin
            @(negedge clk);
            seen = pulse;
        end
        chk("sat_pulse_seen", int'(seen), 1);
        clr = 1;
        @(negedge clk);
        clr = 0;
        chk("clr_vs_drop", int'(overflow), 1);
        ev = 0; clr = 1;
        @(negedge clk);
        clr = 0;
        chk("clr_overflow", int'(overflow), 0);
        repeat (MIN_GAP * (MAXP + 2)) @(negedge clk);
        chk("drain_pending", int'(pending), 0);
        chk("drain_busy", int'(busy), 0);
        for (int i = 0; i < 6; i++) begin
            ev = 1;
            @(negedge clk);
        end
        ev = 0;
        chk("mid_pending", int'(pending), 5);
        #2 rst_n = 0;
        #1;
        chk("async_pulse", int'(pulse), 0);
        chk("async_pending", int'(pending), 0);
        chk("async_overflow", int'(overflow), 0);
        chk("async_busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1;
        n = 0;
        repeat (20) begin
            @(negedge clk);
            n += int'(pulse);
        end
        chk("post_reset_pulses", n, 0);
        dens = 50;
        for (int i = 0; i < 4000; i++) begin
            if (i % 200 == 0) dens = (i / 200) % 4 == 0 ? 10 : (i / 200) % 4 == 1 ? 30 : (i / 200) % 4 == 2 ? 70 : 100;
            ev    = $urandom_range(0, 99) < dens;
            clr   = $urandom_range(0, 99) < 5;
            rst_n = !($urandom_range(0, 599) == 0);
            @(negedge clk);
        end
        rst_n = 1; ev = 0; clr = 0;
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
